// File: rtl/types.sv
// Shared core types: the per-game system configuration consumed by the core.
package types;
  typedef struct packed {
    logic [7:0]  mpu;
    logic [7:0]  screen_config;
    logic [11:0] screen_width;
    logic [11:0] screen_height;
    logic [31:0] input_s0_config;
    logic [31:0] input_s1_config;
    logic [31:0] input_s2_config;
    logic [31:0] input_s3_config;
    logic [31:0] input_s4_config;
    logic [31:0] input_s5_config;
    logic [31:0] input_s6_config;
    logic [31:0] input_s7_config;
    logic [7:0]  input_b_config;
    logic [7:0]  input_ba_config;
    logic [7:0]  input_acl_config;
    logic [3:0]  grounded_port_config;
  } system_config;
endpackage

// File: rtl/gw_config_loader.sv
// Parses the streamed per-game config blob into shadow registers and commits them atomically.
// `config` is a reserved word, so the committed struct is port cfg. Optional: GW_CONFIG_CHECKSUM_EN.
module gw_config_loader #(
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output types::system_config cfg,
  output logic                config_valid,
  output logic                config_error
);

`ifdef GW_CONFIG_CHECKSUM_EN
  localparam int N = 47;
`else
  localparam int N = 46;
`endif
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [2:0] {IDLE, HEADER, BODY, COMMIT, DONE, ERROR} state_t;

  state_t              state;
  logic [5:0]          cnt;
  logic                accept;
  logic                body_wr;
  logic                hdr_bad;
  logic [4:0]          s_off;
  logic [7:0]          sh_mpu;
  logic [7:0]          sh_screen;
  logic [11:0]         sh_width;
  logic [11:0]         sh_height;
  logic [31:0]         sh_s [8];
  logic [7:0]          sh_b;
  logic [7:0]          sh_ba;
  logic [7:0]          sh_acl;
  logic [3:0]          sh_gnd;
  types::system_config shadow;
`ifdef GW_CONFIG_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign accept  = in_valid && in_ready;
  assign body_wr = accept && !start && (state == BODY);
  // Offset within the s0..s7 block; only meaningful while cnt is in 10..41.
  assign s_off   = 5'(cnt - 6'd10);

  always_comb begin
    hdr_bad = 1'b0;
    case (cnt)
      6'd0:    hdr_bad = (in_data != 8'h47);
      6'd1:    hdr_bad = (in_data != 8'h57);
      6'd2:    hdr_bad = (in_data != VERSION);
      default: hdr_bad = 1'b0;
    endcase
  end

  always_comb begin
    shadow                      = '0;
    shadow.mpu                  = sh_mpu;
    shadow.screen_config        = sh_screen;
    shadow.screen_width         = sh_width;
    shadow.screen_height        = sh_height;
    shadow.input_s0_config      = sh_s[0];
    shadow.input_s1_config      = sh_s[1];
    shadow.input_s2_config      = sh_s[2];
    shadow.input_s3_config      = sh_s[3];
    shadow.input_s4_config      = sh_s[4];
    shadow.input_s5_config      = sh_s[5];
    shadow.input_s6_config      = sh_s[6];
    shadow.input_s7_config      = sh_s[7];
    shadow.input_b_config       = sh_b;
    shadow.input_ba_config      = sh_ba;
    shadow.input_acl_config     = sh_acl;
    shadow.grounded_port_config = sh_gnd;
  end

  // Shadow fields are plain data: cleared by start, never read before a commit.
  always_ff @(posedge clk) begin
    if (start) begin
      sh_mpu    <= '0;
      sh_screen <= '0;
      sh_width  <= '0;
      sh_height <= '0;
      sh_b      <= '0;
      sh_ba     <= '0;
      sh_acl    <= '0;
      sh_gnd    <= '0;
      for (int i = 0; i < 8; i++) sh_s[i] <= '0;
    end else if (body_wr) begin
      case (cnt)
        6'd4:    sh_mpu           <= in_data;
        6'd5:    sh_screen        <= in_data;
        6'd6:    sh_width[7:0]    <= in_data;
        6'd7:    sh_width[11:8]   <= in_data[3:0];
        6'd8:    sh_height[7:0]   <= in_data;
        6'd9:    sh_height[11:8]  <= in_data[3:0];
        6'd42:   sh_b             <= in_data;
        6'd43:   sh_ba            <= in_data;
        6'd44:   sh_acl           <= in_data;
        6'd45:   sh_gnd           <= in_data[3:0];
        default: begin
          if (cnt >= 6'd10 && cnt <= 6'd41)
            sh_s[s_off[4:2]][{s_off[1:0], 3'b000} +: 8] <= in_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      cfg          <= '0;
      config_valid <= 1'b0;
      config_error <= 1'b0;
`ifdef GW_CONFIG_CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (start) begin
      // A start drops any byte handshaked in the same cycle.
      state        <= HEADER;
      cnt          <= '0;
      in_ready     <= 1'b1;
      config_valid <= 1'b0;
      config_error <= 1'b0;
`ifdef GW_CONFIG_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        HEADER: begin
          if (accept) begin
`ifdef GW_CONFIG_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (hdr_bad || in_last) begin
              state        <= ERROR;
              config_error <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
              if (cnt == 6'd3) state <= BODY;
            end
          end
        end
        BODY: begin
          if (accept) begin
`ifdef GW_CONFIG_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (cnt == LAST) begin
`ifdef GW_CONFIG_CHECKSUM_EN
              if (in_data != csum) begin
                state        <= ERROR;
                config_error <= 1'b1;
              end else begin
                state    <= COMMIT;
                in_ready <= 1'b0;
              end
`else
              state    <= COMMIT;
              in_ready <= 1'b0;
`endif
            end else if (in_last) begin
              state        <= ERROR;
              config_error <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        COMMIT: begin
          cfg          <= shadow;
          config_valid <= 1'b1;
          in_ready     <= 1'b1;
          state        <= DONE;
        end
        default: begin
          // IDLE waits for start; DONE and ERROR swallow bytes with in_ready held high.
        end
      endcase
    end
  end

endmodule
